// File: rtl/booth_mul_seq_pkg.sv
// Shared encodings for the sequential radix-2 Booth multiplier.
// Holds the FSM states, the Booth recode operations and the iteration count.
package booth_mul_seq_pkg;

  localparam int WIDTH = 32;
  localparam int ITER  = 32;
  localparam int CNT_W = 6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    BOOTH_NOP = 2'd0,
    BOOTH_ADD = 2'd1,
    BOOTH_SUB = 2'd2
  } booth_e;

  // {Q[0], q-1}: 01 adds M, 10 subtracts M, 00/11 leave A unchanged.
  function automatic booth_e booth_recode(input logic q0, input logic qm1);
    booth_e op;
    case ({q0, qm1})
      2'b01:   op = BOOTH_ADD;
      2'b10:   op = BOOTH_SUB;
      default: op = BOOTH_NOP;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/booth_mul_seq_yarith.sv
// 32-bit add/subtract unit: z = a + b (ctrl=0) or a - b (ctrl=1).
// Subtraction is formed as a + ~b + 1; cout is the carry out of bit 31.
module yArith (
  output logic [31:0] z,
  output logic        cout,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        ctrl
);

  logic [31:0] b_eff;
  logic [32:0] sum;

  assign b_eff = ctrl ? ~b : b;
  assign sum   = {1'b0, a} + {1'b0, b_eff} + 33'(ctrl);
  assign z     = sum[31:0];
  assign cout  = sum[32];

endmodule

// File: rtl/booth_mul_seq.sv
// Sequential signed 32x32->64 multiplier: radix-2 Booth over 32 iterations,
// sharing one yArith add/subtract unit; start/ready/done handshake.
module booth_mul_seq
  import booth_mul_seq_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        ready,
  output logic        busy,
  output logic        done,
  output logic [63:0] product
);

  state_e             state_q;
  logic [WIDTH-1:0]   m_q;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   q_q;
  logic               qm1_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [2*WIDTH-1:0] product_q;

  booth_e             op;
  logic               ctrl;
  logic [WIDTH-1:0]   unit_z;
  logic               unit_cout;
  logic [WIDTH-1:0]   s;
  logic               s32;
  logic               beff_msb;
  logic [WIDTH-1:0]   a_d;
  logic [WIDTH-1:0]   q_d;
  logic               accept;
  logic               last_iter;

  assign op   = booth_recode(q_q[0], qm1_q);
  assign ctrl = (op == BOOTH_SUB);

  yArith u_arith (
    .z    (unit_z),
    .cout (unit_cout),
    .a    (a_q),
    .b    (m_q),
    .ctrl (ctrl)
  );

  // Bit 32 of the sign-extended sum keeps A exact even when M = -2^31.
  always_comb begin
    beff_msb = ctrl ? ~m_q[WIDTH-1] : m_q[WIDTH-1];
    s        = a_q;
    s32      = a_q[WIDTH-1];
    if (op != BOOTH_NOP) begin
      s   = unit_z;
      s32 = a_q[WIDTH-1] ^ beff_msb ^ unit_cout;
    end
    a_d = {s32, s[WIDTH-1:1]};
    q_d = {s[0], q_q[WIDTH-1:1]};
  end

  assign accept    = start && (state_q != ST_RUN);
  assign last_iter = (cnt_q == CNT_W'(ITER - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      m_q       <= '0;
      a_q       <= '0;
      q_q       <= '0;
      qm1_q     <= 1'b0;
      cnt_q     <= '0;
      product_q <= '0;
    end else begin
      case (state_q)
        ST_RUN: begin
          a_q   <= a_d;
          q_q   <= q_d;
          qm1_q <= q_q[0];
          cnt_q <= cnt_q + 1'b1;
          if (last_iter) begin
            product_q <= {a_d, q_d};
            state_q   <= ST_DONE;
          end
        end
        default: begin
          if (accept) begin
            m_q     <= a;
            q_q     <= b;
            a_q     <= '0;
            qm1_q   <= 1'b0;
            cnt_q   <= '0;
            state_q <= ST_RUN;
          end else begin
            state_q <= ST_IDLE;
          end
        end
      endcase
    end
  end

  assign ready   = (state_q == ST_IDLE) || (state_q == ST_DONE);
  assign busy    = (state_q == ST_RUN);
  assign done    = (state_q == ST_DONE);
  assign product = product_q;

endmodule
